// File: rtl/sub_bytes_engine.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine: LANES shared S-box lanes
// rewrite the 128-bit working state in place over GROUPS cycles.
module sub_bytes_engine #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [127:0]     work;
    logic [127:0]     work_sub;
    logic [CNT_W-1:0] cnt;
    logic             mode;
    logic             accept;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fwd_affine(input logic [7:0] a);
        return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
                 ^ {a[3:0], a[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inverse);
        return inverse ? gf_inv(inv_affine(b)) : fwd_affine(gf_inv(b));
    endfunction

    // Substitute the current group of bytes; byte k lives at [127-8k -: 8].
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        work_sub = work;
        for (int l = 0; l < LANES; l++) begin
            work_sub[127 - 8 * (int'(cnt) * LANES + l) -: 8] =
                sbox(work[127 - 8 * (int'(cnt) * LANES + l) -: 8], mode);
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST_CNT) state_next = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // Draining the result frees the engine in the same cycle.
                in_ready  = out_ready;
                if (out_ready) state_next = in_valid ? RUN : IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (clr) state_next = IDLE;
    end

    assign accept   = in_valid && in_ready && !clr;
    assign data_out = work;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            work  <= 128'h0;
            cnt   <= '0;
            mode  <= 1'b0;
        end else begin
            state <= state_next;
            if (clr) begin
                cnt <= '0;
            end else if (accept) begin
                work <= data_in;
                mode <= inv;
                cnt  <= '0;
            end else if (state == RUN) begin
                work <= work_sub;
                cnt  <= (cnt == LAST_CNT) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

endmodule
